// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: single-entry decode-to-issue buffer with ROB index allocation,
// flush recovery and a saturating stall counter.
module dispatch_ctrl #(
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 dc_valid,
    input  logic                 dc_is_ls,
    output logic                 dc_accept,
    input  logic                 rob_full,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    input  logic                 flush,
    input  logic [ROB_IDX_W-1:0] rob_head_in,
    output logic                 issue_ready,
    output logic                 issue_rs_ready,
    output logic                 issue_lsb_ready,
    output logic [ROB_IDX_W-1:0] issue_rob_index,
    output logic [15:0]          stall_cycles
);
    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;
    localparam logic [ROB_IDX_W-1:0] ONE = ROB_IDX_W'(1);

    state_t               state;
    logic                 hold_is_ls;
    logic [ROB_IDX_W-1:0] tail;
    logic                 can_issue;
    logic                 xfer;

    assign can_issue = (state == HOLD) && rdy_in && !flush && !rob_full &&
                       (hold_is_ls ? !lsb_full : !rs_full);
    assign dc_accept = rst_in && rdy_in && !flush && (state == EMPTY || can_issue);
    assign xfer      = dc_valid && dc_accept;

    // Index 0 means "no dependency", so the allocator never produces it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= EMPTY;
            hold_is_ls      <= 1'b0;
            tail            <= ONE;
            issue_ready     <= 1'b0;
            issue_rs_ready  <= 1'b0;
            issue_lsb_ready <= 1'b0;
            issue_rob_index <= '0;
            stall_cycles    <= '0;
        end else if (flush) begin
            state           <= FLUSH;
            hold_is_ls      <= 1'b0;
            tail            <= (rob_head_in == '0) ? ONE : rob_head_in;
            issue_ready     <= 1'b0;
            issue_rs_ready  <= 1'b0;
            issue_lsb_ready <= 1'b0;
        end else if (!rdy_in) begin
            issue_ready     <= 1'b0;
            issue_rs_ready  <= 1'b0;
            issue_lsb_ready <= 1'b0;
        end else begin
            issue_ready     <= can_issue;
            issue_rs_ready  <= can_issue && !hold_is_ls;
            issue_lsb_ready <= can_issue && hold_is_ls;
            if (can_issue) begin
                issue_rob_index <= tail;
                tail            <= (tail == '1) ? ONE : tail + ONE;
            end
            if (state == HOLD && !can_issue && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (xfer) begin
                state      <= HOLD;
                hold_is_ls <= dc_is_ls;
            end else if (state == FLUSH || can_issue) begin
                state      <= EMPTY;
                hold_is_ls <= 1'b0;
            end
        end
    end
endmodule
